// File: rtl/priv_ctrl_mu_if.sv
// Commit-stage port bundle for priv_ctrl_mu: CSR access, trap/mret, retire,
// interrupt lines and the resulting redirect/status outputs.
interface priv_ctrl_mu_if #(
   parameter int XLEN     = 64,
   parameter int RETIRE_W = 4
);
   localparam int RCW = $clog2(RETIRE_W + 1);

   logic            i_read_en;
   logic [11:0]     i_read_idx;
   logic            o_read_illegal;
   logic [XLEN-1:0] o_read_val;
   logic            i_write;
   logic [11:0]     i_write_idx;
   logic [XLEN-1:0] i_write_val;
   logic            o_write_illegal;
   logic            i_trap_valid;
   logic [XLEN-1:0] i_trap_cause;
   logic [XLEN-1:0] i_trap_epc;
   logic [XLEN-1:0] i_trap_tval;
   logic            i_mret;
   logic [RCW-1:0]  i_retire_cnt;
   logic            i_msip;
   logic            i_mtip;
   logic            i_meip;
   logic            o_irq_pending;
   logic [XLEN-1:0] o_irq_cause;
   logic            o_redirect_valid;
   logic [XLEN-1:0] o_redirect_pc;
   logic [1:0]      o_mode;
   logic [XLEN-1:0] o_mstatus;

   modport slave (
      input  i_read_en, i_read_idx, i_write, i_write_idx, i_write_val,
             i_trap_valid, i_trap_cause, i_trap_epc, i_trap_tval, i_mret,
             i_retire_cnt, i_msip, i_mtip, i_meip,
      output o_read_illegal, o_read_val, o_write_illegal, o_irq_pending,
             o_irq_cause, o_redirect_valid, o_redirect_pc, o_mode, o_mstatus
   );

   modport master (
      output i_read_en, i_read_idx, i_write, i_write_idx, i_write_val,
             i_trap_valid, i_trap_cause, i_trap_epc, i_trap_tval, i_mret,
             i_retire_cnt, i_msip, i_mtip, i_meip,
      input  o_read_illegal, o_read_val, o_write_illegal, o_irq_pending,
             o_irq_cause, o_redirect_valid, o_redirect_pc, o_mode, o_mstatus
   );
endinterface

// File: rtl/priv_ctrl_mu.sv
// M/U privilege and trap CSR controller with registered redirect and counters.
// Optional U-mode support is enabled by defining PRIV_UMODE_EN.
module priv_ctrl_mu #(
   parameter int              XLEN       = 64,
   parameter int              RETIRE_W   = 4,
   parameter logic [XLEN-1:0] RESET_TVEC = '0,
   parameter logic [XLEN-1:0] HART_ID    = '0
) (
   input  logic          clk,
   input  logic          rst,
   priv_ctrl_mu_if.slave bus
);
   localparam int RCW = $clog2(RETIRE_W + 1);

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   localparam logic [1:0]      PRV_M    = 2'b11;
   localparam logic [1:0]      PRV_U    = 2'b00;
   localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'h888);

`ifdef PRIV_UMODE_EN
   localparam logic UMODE_EN = 1'b1;
`else
   localparam logic UMODE_EN = 1'b0;
`endif

   logic [1:0]      mode_q, mode_d;
   logic            st_mie_q, st_mie_d;
   logic            st_mpie_q, st_mpie_d;
   logic [1:0]      mpp_q, mpp_d;
   logic [XLEN-1:0] mie_q, mie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mtval_q, mtval_d;
   logic [XLEN-1:0] mip_q, mip_d;
   logic [XLEN-1:0] mcycle_q, mcycle_d;
   logic [XLEN-1:0] minstret_q, minstret_d;
   logic            redir_vld_q, redir_vld_d;
   logic [XLEN-1:0] redir_pc_q, redir_pc_d;

   logic [XLEN-1:0] mstatus_val;
   logic [XLEN-1:0] rd_data;
   logic            rd_ill;
   logic            wr_ill;
   logic            wr_en;
   logic [XLEN-1:0] tvec_base;
   logic [XLEN-1:0] trap_pc;
   logic [XLEN-1:0] irq_vec;
   logic            irq_gate;
   logic            irq_pend;

   function automatic logic is_mapped(input logic [11:0] a);
      case (a)
         CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
         CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MHARTID: is_mapped = 1'b1;
         default: is_mapped = 1'b0;
      endcase
   endfunction

   // Without U-mode the only legal MPP is M; with it, reserved encodings fold to U.
   function automatic logic [1:0] warl_mpp(input logic [1:0] v);
      if (!UMODE_EN)      warl_mpp = PRV_M;
      else if (v == PRV_M) warl_mpp = PRV_M;
      else                warl_mpp = PRV_U;
   endfunction

   always_comb begin
      mstatus_val        = '0;
      mstatus_val[3]     = st_mie_q;
      mstatus_val[7]     = st_mpie_q;
      mstatus_val[12:11] = mpp_q;
   end

   assign rd_ill = !is_mapped(bus.i_read_idx) || (bus.i_read_idx[9:8] > mode_q);
   assign wr_ill = !is_mapped(bus.i_write_idx) || (bus.i_write_idx[11:10] == 2'b11) ||
                   (bus.i_write_idx[9:8] > mode_q);
   assign wr_en  = bus.i_write && !wr_ill && !bus.i_trap_valid && !bus.i_mret;

   always_comb begin
      rd_data = '0;
      case (bus.i_read_idx)
         CSR_MSTATUS:  rd_data = mstatus_val;
         CSR_MIE:      rd_data = mie_q;
         CSR_MTVEC:    rd_data = mtvec_q;
         CSR_MSCRATCH: rd_data = mscratch_q;
         CSR_MEPC:     rd_data = mepc_q;
         CSR_MCAUSE:   rd_data = mcause_q;
         CSR_MTVAL:    rd_data = mtval_q;
         CSR_MIP:      rd_data = mip_q;
         CSR_MCYCLE:   rd_data = mcycle_q;
         CSR_MINSTRET: rd_data = minstret_q;
         CSR_MHARTID:  rd_data = HART_ID;
         default:      rd_data = '0;
      endcase
   end

   // Vectored mode only offsets interrupts; exceptions always land on the base.
   assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
   assign trap_pc   = (mtvec_q[1:0] == 2'b01 && bus.i_trap_cause[XLEN-1])
                    ? tvec_base + {bus.i_trap_cause[XLEN-3:0], 2'b00} : tvec_base;

   assign irq_vec = mip_q & mie_q;
`ifdef PRIV_UMODE_EN
   assign irq_gate = (mode_q == PRV_U) || st_mie_q;
`else
   assign irq_gate = st_mie_q;
`endif
   assign irq_pend = (|irq_vec) && irq_gate;

   always_comb begin
      bus.o_irq_cause = '0;
      if (irq_pend) begin
         bus.o_irq_cause[XLEN-1] = 1'b1;
         if (irq_vec[11])     bus.o_irq_cause[3:0] = 4'd11;
         else if (irq_vec[3]) bus.o_irq_cause[3:0] = 4'd3;
         else                 bus.o_irq_cause[3:0] = 4'd7;
      end
   end

   always_comb begin
      mode_d      = mode_q;
      st_mie_d    = st_mie_q;
      st_mpie_d   = st_mpie_q;
      mpp_d       = mpp_q;
      mie_d       = mie_q;
      mtvec_d     = mtvec_q;
      mscratch_d  = mscratch_q;
      mepc_d      = mepc_q;
      mcause_d    = mcause_q;
      mtval_d     = mtval_q;
      mip_d       = '0;
      mip_d[3]    = bus.i_msip;
      mip_d[7]    = bus.i_mtip;
      mip_d[11]   = bus.i_meip;
      mcycle_d    = mcycle_q + 1'b1;
      minstret_d  = minstret_q + {{(XLEN-RCW){1'b0}}, bus.i_retire_cnt};
      redir_vld_d = 1'b0;
      redir_pc_d  = redir_pc_q;
      if (bus.i_trap_valid) begin
         mepc_d      = {bus.i_trap_epc[XLEN-1:1], 1'b0};
         mcause_d    = bus.i_trap_cause;
         mtval_d     = bus.i_trap_tval;
         mpp_d       = warl_mpp(mode_q);
         st_mpie_d   = st_mie_q;
         st_mie_d    = 1'b0;
         mode_d      = PRV_M;
         redir_vld_d = 1'b1;
         redir_pc_d  = trap_pc;
      end else if (bus.i_mret) begin
         mode_d      = UMODE_EN ? mpp_q : PRV_M;
         st_mie_d    = st_mpie_q;
         st_mpie_d   = 1'b1;
         mpp_d       = warl_mpp(PRV_U);
         redir_vld_d = 1'b1;
         redir_pc_d  = mepc_q;
      end else if (wr_en) begin
         case (bus.i_write_idx)
            CSR_MSTATUS: begin
               st_mie_d  = bus.i_write_val[3];
               st_mpie_d = bus.i_write_val[7];
               mpp_d     = warl_mpp(bus.i_write_val[12:11]);
            end
            CSR_MIE:      mie_d      = bus.i_write_val & IRQ_MASK;
            CSR_MTVEC:    mtvec_d    = bus.i_write_val[1] ? {bus.i_write_val[XLEN-1:2], 2'b00}
                                                          : bus.i_write_val;
            CSR_MSCRATCH: mscratch_d = bus.i_write_val;
            CSR_MEPC:     mepc_d     = {bus.i_write_val[XLEN-1:1], 1'b0};
            CSR_MCAUSE:   mcause_d   = bus.i_write_val;
            CSR_MTVAL:    mtval_d    = bus.i_write_val;
            CSR_MCYCLE:   mcycle_d   = bus.i_write_val;
            CSR_MINSTRET: minstret_d = bus.i_write_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q      <= PRV_M;
         st_mie_q    <= 1'b0;
         st_mpie_q   <= 1'b0;
         mpp_q       <= warl_mpp(PRV_U);
         mie_q       <= '0;
         mtvec_q     <= RESET_TVEC;
         mscratch_q  <= '0;
         mepc_q      <= '0;
         mcause_q    <= '0;
         mtval_q     <= '0;
         mip_q       <= '0;
         mcycle_q    <= '0;
         minstret_q  <= '0;
         redir_vld_q <= 1'b0;
         redir_pc_q  <= '0;
      end else begin
         mode_q      <= mode_d;
         st_mie_q    <= st_mie_d;
         st_mpie_q   <= st_mpie_d;
         mpp_q       <= mpp_d;
         mie_q       <= mie_d;
         mtvec_q     <= mtvec_d;
         mscratch_q  <= mscratch_d;
         mepc_q      <= mepc_d;
         mcause_q    <= mcause_d;
         mtval_q     <= mtval_d;
         mip_q       <= mip_d;
         mcycle_q    <= mcycle_d;
         minstret_q  <= minstret_d;
         redir_vld_q <= redir_vld_d;
         redir_pc_q  <= redir_pc_d;
      end
   end

   assign bus.o_read_illegal   = rd_ill;
   assign bus.o_read_val       = (bus.i_read_en && !rd_ill) ? rd_data : '0;
   assign bus.o_write_illegal  = wr_ill;
   assign bus.o_irq_pending    = irq_pend;
   assign bus.o_redirect_valid = redir_vld_q;
   assign bus.o_redirect_pc    = redir_pc_q;
   assign bus.o_mode           = mode_q;
   assign bus.o_mstatus        = mstatus_val;
endmodule
